// File: rtl/wb_stream_port.sv
// wb_stream_port
// Multi-channel Wishbone-to-byte-stream bridge. Each channel owns a TX FIFO
// (CPU -> device) and an RX FIFO (device -> CPU), both first-word-fall-through
// and 2**DEPTH_LOG2 bytes deep. Per channel, the bus sees a DATA register
// (push TX / pop RX) and a STATUS register (levels, counts, sticky errors).
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   adr_i                 byte address: [ADDR_WIDTH-1:3] channel, [2] register
//   dat_i, dat_o          write data / registered read data
//   we_i, sel_i           write enable / byte selects (only sel_i[0] matters)
//   stb_i, cyc_i, ack_o   Wishbone handshake, single-cycle registered ack
//   tx_data/valid/ready   per-channel outgoing byte stream
//   rx_data/valid/ready   per-channel incoming byte stream
//   irq                   per-channel RX-data-available
module wb_stream_port #(
    parameter int CHANNELS   = 2,
    parameter int DEPTH_LOG2 = 4,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   adr_i,
    input  logic [31:0]             dat_i,
    output logic [31:0]             dat_o,
    input  logic                    we_i,
    input  logic [3:0]              sel_i,
    input  logic                    stb_i,
    input  logic                    cyc_i,
    output logic                    ack_o,
    output logic [8*CHANNELS-1:0]   tx_data,
    output logic [CHANNELS-1:0]     tx_valid,
    input  logic [CHANNELS-1:0]     tx_ready,
    input  logic [8*CHANNELS-1:0]   rx_data,
    input  logic [CHANNELS-1:0]     rx_valid,
    output logic [CHANNELS-1:0]     rx_ready,
    output logic [CHANNELS-1:0]     irq
);

    localparam int CW = ADDR_WIDTH - 3;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic          accept;
    logic [CW-1:0] ch_sel;
    logic          is_status;
    logic [31:0]   ch_rdata [CHANNELS];
    logic [31:0]   rd_value;
    logic          unused_bits;

    // A request is taken only while ack_o is low, so each access costs two cycles.
    assign accept      = cyc_i & stb_i & ~ack_o;
    assign ch_sel      = adr_i[ADDR_WIDTH-1:3];
    assign is_status   = adr_i[2];
    assign unused_bits = ^{dat_i[31:8], sel_i[3:1], adr_i[1:0]};

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [7:0]            tx_mem [1 << DEPTH_LOG2];
        logic [7:0]            rx_mem [1 << DEPTH_LOG2];
        logic [DEPTH_LOG2-1:0] tx_wr, tx_rd, rx_wr, rx_rd;
        logic [DEPTH_LOG2:0]   tx_cnt, rx_cnt;
        logic                  tx_drop, rx_under;
        logic                  hit, w1c;
        logic                  tx_full, tx_empty, rx_full, rx_empty;
        logic                  tx_push_req, tx_push, tx_pop;
        logic                  rx_pop_req, rx_pop, rx_push;

        // Out-of-range channels match no generate instance, so they never hit.
        assign hit         = accept & (32'(ch_sel) == c);
        assign tx_full     = (tx_cnt == FULL_CNT);
        assign tx_empty    = (tx_cnt == '0);
        assign rx_full     = (rx_cnt == FULL_CNT);
        assign rx_empty    = (rx_cnt == '0);

        // All full/empty decisions use the pre-edge counts.
        assign tx_push_req = hit & we_i & sel_i[0] & ~is_status;
        assign tx_push     = tx_push_req & ~tx_full;
        assign tx_pop      = ~tx_empty & tx_ready[c];
        assign rx_pop_req  = hit & ~we_i & ~is_status;
        assign rx_pop      = rx_pop_req & ~rx_empty;
        assign rx_push     = rx_valid[c] & rx_ready[c];
        assign w1c         = hit & we_i & sel_i[0] & is_status;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                tx_wr    <= '0;
                tx_rd    <= '0;
                rx_wr    <= '0;
                rx_rd    <= '0;
                tx_cnt   <= '0;
                rx_cnt   <= '0;
                tx_drop  <= 1'b0;
                rx_under <= 1'b0;
            end else begin
                if (tx_push) tx_wr <= tx_wr + 1'b1;
                if (tx_pop)  tx_rd <= tx_rd + 1'b1;
                if (rx_push) rx_wr <= rx_wr + 1'b1;
                if (rx_pop)  rx_rd <= rx_rd + 1'b1;

                if (tx_push & ~tx_pop)      tx_cnt <= tx_cnt + 1'b1;
                else if (~tx_push & tx_pop) tx_cnt <= tx_cnt - 1'b1;
                if (rx_push & ~rx_pop)      rx_cnt <= rx_cnt + 1'b1;
                else if (~rx_push & rx_pop) rx_cnt <= rx_cnt - 1'b1;

                // Setting a sticky bit takes priority over clearing it.
                if (tx_push_req & tx_full)  tx_drop <= 1'b1;
                else if (w1c & dat_i[2])    tx_drop <= 1'b0;
                if (rx_pop_req & rx_empty)  rx_under <= 1'b1;
                else if (w1c & dat_i[3])    rx_under <= 1'b0;
            end
        end

        always_ff @(posedge clk) begin
            if (tx_push) tx_mem[tx_wr] <= dat_i[7:0];
            if (rx_push) rx_mem[rx_wr] <= rx_data[8*c +: 8];
        end

        assign tx_data[8*c +: 8] = tx_mem[tx_rd];
        assign tx_valid[c]       = ~tx_empty;
        assign rx_ready[c]       = ~rst & ~rx_full;
        assign irq[c]            = ~rx_empty;

        assign ch_rdata[c] = is_status
            ? {8'h00, 8'(tx_cnt), 8'(rx_cnt), 4'h0, rx_under, tx_drop, ~tx_full, ~rx_empty}
            : (rx_empty ? 32'h0 : {24'h0, rx_mem[rx_rd]});
    end

    always_comb begin
        rd_value = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (32'(ch_sel) == c) rd_value = ch_rdata[c];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_o <= 1'b0;
            dat_o <= '0;
        end else begin
            ack_o <= accept;
            if (accept & ~we_i) dat_o <= rd_value;
        end
    end

endmodule

// File: tb/tb_wb_stream_port.sv
// tb_wb_stream_port
// Self-checking bench for wb_stream_port (2 channels, 16-byte FIFOs).
// A queue-based reference model tracks FIFO contents, sticky bits and the
// bus read path; a monitor compares every output against it on each falling
// edge. Directed table vectors and hand sequences cover the corner cases,
// followed by a randomized phase.
`timescale 1ns/1ps
module tb_wb_stream_port;

    localparam int CH    = 2;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    adr;
    logic [31:0]   dat_w;
    logic [31:0]   dat_o;
    logic          we, stb, cyc;
    logic [3:0]    sel;
    logic          ack_o;
    logic [15:0]   tx_data;
    logic [1:0]    tx_valid, tx_ready;
    logic [15:0]   rx_data;
    logic [1:0]    rx_valid, rx_ready;
    logic [1:0]    irq;

    int ntest = 0;
    int nfail = 0;

    wb_stream_port #(.CHANNELS(2), .DEPTH_LOG2(4), .ADDR_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .adr_i(adr), .dat_i(dat_w), .dat_o(dat_o),
        .we_i(we), .sel_i(sel), .stb_i(stb), .cyc_i(cyc), .ack_o(ack_o),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntest++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  txq [CH][$];
    logic [7:0]  rxq [CH][$];
    bit          m_drop  [CH];
    bit          m_under [CH];
    logic        m_ack = 1'b0;
    logic [31:0] m_dat = 32'h0;

    always @(posedge clk or posedge rst) begin : model
        bit          acc;
        int          ch;
        logic [31:0] rv;
        bit          txp [CH];
        bit          rxp [CH];
        if (rst) begin
            for (int c = 0; c < CH; c++) begin
                txq[c].delete();
                rxq[c].delete();
                m_drop[c]  = 0;
                m_under[c] = 0;
            end
            m_ack = 1'b0;
            m_dat = 32'h0;
        end else begin
            acc = cyc && stb && !m_ack;
            ch  = int'(adr[7:3]);
            rv  = 32'h0;
            for (int c = 0; c < CH; c++) begin
                txp[c] = (txq[c].size() > 0) && tx_ready[c];
                rxp[c] = rx_valid[c] && (rxq[c].size() < DEPTH);
            end
            if (acc && ch < CH) begin
                if (we) begin
                    if (sel[0]) begin
                        if (!adr[2]) begin
                            if (txq[ch].size() == DEPTH) m_drop[ch] = 1;
                            else txq[ch].push_back(dat_w[7:0]);
                        end else begin
                            if (dat_w[2]) m_drop[ch]  = 0;
                            if (dat_w[3]) m_under[ch] = 0;
                        end
                    end
                end else if (!adr[2]) begin
                    if (rxq[ch].size() == 0) m_under[ch] = 1;
                    else rv = {24'h0, rxq[ch].pop_front()};
                end else begin
                    rv = {8'h00, 8'(txq[ch].size()), 8'(rxq[ch].size()), 4'h0,
                          m_under[ch], m_drop[ch], txq[ch].size() != DEPTH, rxq[ch].size() != 0};
                end
            end
            for (int c = 0; c < CH; c++) begin
                if (txp[c]) void'(txq[c].pop_front());
                if (rxp[c]) rxq[c].push_back(rx_data[8*c +: 8]);
            end
            m_ack = acc;
            if (acc && !we) m_dat = rv;
        end
    end

    always @(negedge clk) begin
        chk("ack_o", 32'(ack_o), 32'(m_ack));
        chk("dat_o", dat_o, m_dat);
        for (int c = 0; c < CH; c++) begin
            chk("tx_valid", 32'(tx_valid[c]), 32'(txq[c].size() > 0));
            if (txq[c].size() > 0) chk("tx_data", 32'(tx_data[8*c +: 8]), 32'(txq[c][0]));
            chk("irq", 32'(irq[c]), 32'(rxq[c].size() > 0));
            chk("rx_ready", 32'(rx_ready[c]), 32'(!rst && rxq[c].size() < DEPTH));
        end
    end

    // ---------------- bus helpers ----------------
    task automatic bus_req(input logic [7:0] a, input logic w, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] r);
        @(negedge clk);
        adr = a; we = w; dat_w = d; sel = s; cyc = 1'b1; stb = 1'b1;
        @(posedge clk);
        #1;
        chk("ack_high", 32'(ack_o), 32'h1);
        r = dat_o;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic bus_idle();
        @(posedge clk);
        #1;
        chk("ack_drop", 32'(ack_o), 32'h0);
    endtask

    task automatic bus(input logic [7:0] a, input logic w, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] r);
        bus_req(a, w, d, s, r);
        bus_idle();
    endtask

    typedef struct {
        logic [7:0]  adr;
        logic        we;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [13];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [31:0] r;
        bit          done;

        tbl[0]  = '{8'h04, 1'b0, 32'h0,        4'hF, 32'h0000_0002};
        tbl[1]  = '{8'h0C, 1'b0, 32'h0,        4'hF, 32'h0000_0002};
        tbl[2]  = '{8'h00, 1'b0, 32'h0,        4'hF, 32'h0000_0000};
        tbl[3]  = '{8'h04, 1'b0, 32'h0,        4'hF, 32'h0000_000A};
        tbl[4]  = '{8'h04, 1'b1, 32'h8,        4'h1, 32'h0000_000A};
        tbl[5]  = '{8'h04, 1'b0, 32'h0,        4'hF, 32'h0000_0002};
        tbl[6]  = '{8'h08, 1'b1, 32'h41,       4'hE, 32'h0000_0002};
        tbl[7]  = '{8'h0C, 1'b0, 32'h0,        4'hF, 32'h0000_0002};
        tbl[8]  = '{8'h09, 1'b1, 32'h55,       4'h1, 32'h0000_0002};
        tbl[9]  = '{8'h0F, 1'b0, 32'h0,        4'hF, 32'h0001_0002};
        tbl[10] = '{8'h18, 1'b0, 32'h0,        4'hF, 32'h0000_0000};
        tbl[11] = '{8'h18, 1'b1, 32'hFF,       4'hF, 32'h0000_0000};
        tbl[12] = '{8'h0C, 1'b0, 32'h0,        4'hF, 32'h0001_0002};

        rst = 1'b1; adr = '0; dat_w = '0; we = 0; stb = 0; cyc = 0; sel = '0;
        tx_ready = '0; rx_valid = '0; rx_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_ack", 32'(ack_o), 32'h0);
        chk("reset_dat", dat_o, 32'h0);
        chk("reset_txv", 32'(tx_valid), 32'h0);
        chk("reset_irq", 32'(irq), 32'h0);
        chk("reset_rxrdy", 32'(rx_ready), 32'h3);

        // Directed register vectors
        for (int i = 0; i < 13; i++) begin
            bus(tbl[i].adr, tbl[i].we, tbl[i].dat, tbl[i].sel, r);
            chk($sformatf("vec%0d", i), dat_o, tbl[i].exp);
        end
        tx_ready = 2'b10;
        @(posedge clk); #1;
        tx_ready = 2'b00;
        chk("drain_ch1", 32'(tx_valid), 32'h0);

        // Two bytes on ch1, released in consecutive cycles
        bus(8'h08, 1'b1, 32'h41, 4'h1, r);
        bus(8'h08, 1'b1, 32'h42, 4'h1, r);
        bus(8'h0C, 1'b0, 32'h0, 4'hF, r);
        chk("ch1_cnt2", r, 32'h0002_0002);
        @(negedge clk);
        chk("tx_head_41", 32'(tx_data[15:8]), 32'h41);
        tx_ready = 2'b10;
        @(negedge clk);
        chk("tx_head_42", 32'(tx_data[15:8]), 32'h42);
        @(negedge clk);
        chk("tx_empty_ch1", 32'(tx_valid[1]), 32'h0);
        tx_ready = 2'b00;
        bus(8'h0C, 1'b0, 32'h0, 4'hF, r);
        chk("ch1_cnt0", r, 32'h0000_0002);

        // Overfill TX ch0, clear drop, then write-while-popping on full
        for (int i = 0; i < 17; i++) bus(8'h00, 1'b1, 32'(i), 4'h1, r);
        bus(8'h04, 1'b0, 32'h0, 4'hF, r);
        chk("tx_full_stat", r, 32'h0010_0004);
        bus(8'h04, 1'b1, 32'h4, 4'h1, r);
        bus(8'h04, 1'b0, 32'h0, 4'hF, r);
        chk("tx_drop_clr", r, 32'h0010_0000);
        tx_ready = 2'b01;
        bus_req(8'h00, 1'b1, 32'hAA, 4'h1, r);
        tx_ready = 2'b00;
        bus_idle();
        bus(8'h04, 1'b0, 32'h0, 4'hF, r);
        chk("full_wr_pop", r, 32'h000F_0006);
        bus(8'h04, 1'b1, 32'h4, 4'h1, r);
        tx_ready = 2'b01;
        for (int k = 1; k < 16; k++) begin
            @(negedge clk);
            chk($sformatf("tx0_byte%0d", k), 32'(tx_data[7:0]), 32'(k));
        end
        @(posedge clk); #1;
        tx_ready = 2'b00;
        chk("tx0_empty", 32'(tx_valid[0]), 32'h0);

        // RX ch0: two bytes, read out, then underflow
        rx_valid = 2'b01; rx_data[7:0] = 8'h1C;
        @(posedge clk); #1;
        rx_data[7:0] = 8'h32;
        @(posedge clk); #1;
        rx_valid = 2'b00;
        chk("irq0_set", 32'(irq[0]), 32'h1);
        bus(8'h00, 1'b0, 32'h0, 4'hF, r);
        chk("rx_1c", r, 32'h1C);
        bus(8'h00, 1'b0, 32'h0, 4'hF, r);
        chk("rx_32", r, 32'h32);
        bus(8'h00, 1'b0, 32'h0, 4'hF, r);
        chk("rx_under_rd", r, 32'h0);
        bus(8'h04, 1'b0, 32'h0, 4'hF, r);
        chk("rx_under_stat", r, 32'h0000_000A);
        chk("irq0_clr", 32'(irq[0]), 32'h0);
        rx_valid = 2'b01; rx_data[7:0] = 8'h77;
        bus_req(8'h00, 1'b0, 32'h0, 4'hF, r);
        rx_valid = 2'b00;
        bus_idle();
        chk("empty_rd_push", r, 32'h0);
        bus(8'h00, 1'b0, 32'h0, 4'hF, r);
        chk("rx_77", r, 32'h77);
        bus(8'h04, 1'b1, 32'h8, 4'h1, r);

        // Fill RX ch1, read with a held push pending
        rx_valid = 2'b10;
        for (int i = 0; i < 16; i++) begin
            rx_data[15:8] = 8'(8'hA0 + i);
            @(posedge clk); #1;
        end
        rx_data[15:8] = 8'hEE;
        chk("rx1_full_rdy", 32'(rx_ready[1]), 32'h0);
        bus_req(8'h08, 1'b0, 32'h0, 4'hF, r);
        chk("rx1_oldest", r, 32'hA0);
        chk("rx1_rdy_back", 32'(rx_ready[1]), 32'h1);
        bus_idle();
        rx_valid = 2'b00;
        chk("rx1_refull", 32'(rx_ready[1]), 32'h0);
        bus(8'h0C, 1'b0, 32'h0, 4'hF, r);
        chk("rx1_cnt16", r, 32'h0000_1003);
        for (int i = 1; i < 16; i++) begin
            bus(8'h08, 1'b0, 32'h0, 4'hF, r);
            chk($sformatf("rx1_byte%0d", i), r, 32'(8'hA0 + i));
        end
        bus(8'h08, 1'b0, 32'h0, 4'hF, r);
        chk("rx1_held", r, 32'hEE);

        // Reset in the middle of an access with FIFOs half full
        rx_valid = 2'b01;
        for (int i = 0; i < 8; i++) begin
            rx_data[7:0] = 8'(i + 1);
            @(posedge clk); #1;
        end
        rx_valid = 2'b00;
        for (int i = 0; i < 8; i++) bus(8'h00, 1'b1, 32'(8'h60 + i), 4'h1, r);
        bus(8'h04, 1'b0, 32'h0, 4'hF, r);
        chk("half_full", r, 32'h0008_0803);
        @(negedge clk);
        adr = 8'h04; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("rst_ack_drop", 32'(ack_o), 32'h0);
        chk("rst_txv", 32'(tx_valid), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_rxrdy", 32'(rx_ready), 32'h0);
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel_rxrdy", 32'(rx_ready), 32'h3);
        bus(8'h04, 1'b0, 32'h0, 4'hF, r);
        chk("rel_ch0", r, 32'h0000_0002);
        bus(8'h0C, 1'b0, 32'h0, 4'hF, r);
        chk("rel_ch1", r, 32'h0000_0002);
        bus(8'h04, 1'b0, 32'h0, 4'hF, r);
        bus(8'h18, 1'b0, 32'h0, 4'hF, r);
        chk("oor_ch3", r, 32'h0);

        // Randomized traffic against the model
        done = 0;
        fork
            begin
                for (int n = 0; n < 400; n++) begin
                    bus($urandom_range(0, 31), $urandom_range(0, 1) == 1, $urandom,
                        4'($urandom), r);
                end
                done = 1;
            end
            begin
                while (!done) begin
                    @(negedge clk);
                    tx_ready = 2'($urandom);
                    rx_valid = 2'($urandom);
                    rx_data  = 16'($urandom);
                end
            end
        join
        tx_ready = '0;
        rx_valid = '0;
        repeat (2) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end

endmodule

// File: doc/wb_stream_port.md
# wb_stream_port

Multi-channel Wishbone-to-byte-stream bridge on the 32-bit narrow I/O bus, behind the width adapter. It succeeds the single-register LED port as the generic I/O peripheral for the UART TX/RX and PS/2 scan streams. Each channel has a TX FIFO (CPU -> device) and an RX FIFO (device -> CPU), each `2**DEPTH_LOG2` bytes deep. Each channel is exposed as one DATA register and one STATUS register.

## Interface
Parameters:
- `CHANNELS`, 2, number of stream channels (1..16)
- `DEPTH_LOG2`, 4, log2 of the per-direction FIFO depth in bytes (1..7)
- `ADDR_WIDTH`, 8, byte-address width seen by the block; must be >= 3 + clog2(CHANNELS)

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-high.
  - `clk`  in  1  clock
  - `rst`  in  1  asynchronous active-high reset
- Wishbone slave:
  - `adr_i`  in  ADDR_WIDTH  byte address
  - `dat_i`  in  32  write data
  - `dat_o`  out  32  read data, registered
  - `we_i`  in  1  write enable
  - `sel_i`  in  4  byte selects
  - `stb_i`  in  1  strobe
  - `cyc_i`  in  1  cycle
  - `ack_o`  out  1  acknowledge, registered
- TX stream (block -> device):
  - `tx_data`  out  8*CHANNELS  channel c at bits [8c+7:8c]
  - `tx_valid`  out  CHANNELS  per-channel valid
  - `tx_ready`  in  CHANNELS  per-channel ready
- RX stream (device -> block):
  - `rx_data`  in  8*CHANNELS  channel c at bits [8c+7:8c]
  - `rx_valid`  in  CHANNELS  per-channel valid
  - `rx_ready`  out  CHANNELS  per-channel ready
- Interrupt:
  - `irq`  out  CHANNELS  per-channel RX-data-available

## Operation
- Address decode:
  - channel = `adr_i[ADDR_WIDTH-1:3]`
  - register = `adr_i[2]` (0 = DATA, 1 = STATUS)
  - `adr_i[1:0]` is ignored.
- Out-of-range channel: reads return 0; writes have no effect; the access is still acked.
- DATA write (requires `sel_i[0]`): pushes `dat_i[7:0]` into the TX FIFO.
  - If the TX FIFO is full, the byte is dropped and sticky TX_DROP is set.
  - If `sel_i[0]=0`, there is no effect.
- DATA read: pops the RX FIFO and returns {24'h0, byte}.
  - If the RX FIFO is empty, it returns 0, does not pop, and sets sticky RX_UNDER.
- STATUS read (no side effects):
  - bit0 RX_AVAIL = RX FIFO non-empty
  - bit1 TX_SPACE = TX FIFO not full
  - bit2 TX_DROP
  - bit3 RX_UNDER
  - [15:8] RX byte count
  - [23:16] TX byte count
  - all other bits 0
- STATUS write (requires `sel_i[0]`): write-1-to-clear on bits 2 and 3; all other bits are ignored.
- FIFOs are first-word-fall-through.
  - `tx_valid[c]` = TX FIFO non-empty; `tx_data` = head byte.
  - The TX FIFO pops on the cycle where `tx_valid & tx_ready`.
- `rx_ready[c]` = !rst & RX FIFO not full. The RX FIFO pushes on the cycle where `rx_valid & rx_ready`.
- `irq[c]` = RX_AVAIL of channel c.
- Counts run from 0 to `2**DEPTH_LOG2` (DEPTH_LOG2 + 1 bits, zero-extended into the 8-bit fields). Pointers wrap modulo depth.

## Timing
- Reset values:
  - `ack_o`=0, `dat_o`=0, `tx_valid`=0, `irq`=0
  - all FIFOs empty, sticky bits 0
  - `rx_ready`=0 while `rst` is high and 1 after release
- Request acceptance:
  - A request is accepted in a cycle with `cyc_i & stb_i & !ack_o`.
  - At that cycle's rising edge, `ack_o`<=1, `dat_o`<=read value, and the FIFO/sticky side effect occurs.
  - `ack_o` is high for exactly one cycle, then drops.
  - Back-to-back requests are therefore accepted no faster than every 2 cycles.
- `dat_o` holds its value until the next accepted read.
- Writes leave `dat_o` unchanged.
- Full/empty are evaluated on pre-edge state:
  - Bus write + stream pop on a full TX FIFO in the same cycle: the write is dropped (TX_DROP set) and the pop occurs.
  - Bus pop + stream push on a full RX FIFO in the same cycle: there is no push, since `rx_ready` was 0, and the pop occurs.
  - Simultaneous push and pop on a non-full, non-empty FIFO: both occur; the count is unchanged.
  - A read from an empty RX FIFO coincident with a stream push returns 0 (RX_UNDER set); the pushed byte is readable afterwards.
- Setting a sticky bit in the same cycle as a W1C write to that bit: set wins.
- Reset asserted mid-transfer: all state clears immediately and `ack_o` drops. The pending request is lost, and the master must retry.
- Latency:
  - A bus write reaches `tx_valid` 1 cycle after the accept edge.
  - A stream push is visible in STATUS and `irq` 1 cycle after the push edge.

## Test plan
- Reset release, then STATUS read of ch0 -> `dat_o`=32'h0000_0002, `ack_o` high exactly one cycle after accept, `rx_ready`=2'b11.
- Write DATA ch1 = 0x41, 0x42 with `tx_ready`=0, then raise `tx_ready` -> `tx_data[15:8]` = 0x41 then 0x42 on consecutive cycles, then `tx_valid[1]`=0; ch1 STATUS [23:16] goes 2 -> 0.
- With `tx_ready`=0, write ch0 17 times (DEPTH_LOG2=4) -> 17th is dropped, STATUS = 32'h0010_0004; write 0x4 to STATUS -> bit2 clears.
- Push 0x1C, 0x32 on RX ch0 -> `irq[0]`=1; two DATA reads return 0x1C, 0x32; a third returns 0 with RX_UNDER set; `irq[0]`=0.
- Fill RX ch1 to 16 -> `rx_ready[1]`=0; hold `rx_valid`, read once -> the read returns the oldest byte, `rx_ready[1]` returns to 1, the held byte is pushed next cycle, and the count returns to 16.
- Assert `rst` mid-access with FIFOs half full -> `ack_o` drops at once, all counts read 0 after release, and out-of-range channel 3 read returns 0 with ack.
